// File: rtl/vec_dot_product.sv
// vec_dot_product: sequential multiply-accumulate over VECTOR_LEN 32-bit
// element pairs. One element pair is consumed per enabled clock. When the
// last pair is accumulated, done and result are registered and then held
// until the next reset. All arithmetic is modulo 2^32, which makes signed
// and unsigned operands give identical results.
module vec_dot_product #(
    parameter int VECTOR_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [VECTOR_LEN*32-1:0] vector1,
    input  logic [VECTOR_LEN*32-1:0] vector2,
    output logic [31:0]              result,
    output logic                     done
);

    // Wide enough to hold VECTOR_LEN itself, so the counter can reach the
    // terminal value without wrapping.
    localparam int IDX_W = $clog2(VECTOR_LEN + 1);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [31:0]      acc;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [31:0]      prod;
    logic [31:0]      sum;
    logic             last;

    // Pick the element pair addressed by index; out-of-range reads zero.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < VECTOR_LEN; i++) begin
            if (index == IDX_W'(i)) begin
                sel_a = vector1[32*i +: 32];
                sel_b = vector2[32*i +: 32];
            end
        end
    end

    // Only the low 32 bits of the product are ever needed, so a
    // 32-bit-wide multiply expression is used directly.
    assign prod = sel_a * sel_b;
    assign sum  = acc + prod;
    assign last = (index == IDX_W'(VECTOR_LEN - 1));

    // Two-state control: accumulate in RUN, freeze outputs in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            index  <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        acc   <= sum;
                        index <= index + IDX_W'(1);
                        if (last) begin
                            state  <= DONE;
                            result <= sum;
                            done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Hold result and done until the next reset.
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_product.sv
// Directed bench for vec_dot_product: a table of operand/result records is
// run through a VECTOR_LEN=4 instance, followed by hand-written sequences
// for enable gating, resets during and after a run, and a VECTOR_LEN=1
// instance for the single-element boundary.
module tb_vec_dot_product;

    logic         clk = 1'b0;
    logic         rst4, en4;
    logic [127:0] a4, b4;
    logic [31:0]  res4;
    logic         done4;
    logic         rst1, en1;
    logic [31:0]  a1, b1;
    logic [31:0]  res1;
    logic         done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vec_dot_product #(.VECTOR_LEN(4)) dut4 (
        .clk(clk), .rst(rst4), .enable(en4),
        .vector1(a4), .vector2(b4), .result(res4), .done(done4)
    );

    vec_dot_product #(.VECTOR_LEN(1)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1),
        .vector1(a1), .vector2(b1), .result(res1), .done(done1)
    );

    typedef struct {
        string        nm;
        logic [127:0] a;
        logic [127:0] b;
        logic [31:0]  exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset on the 4-lane instance for one edge with new operands.
    task automatic reset4(input logic [127:0] a, input logic [127:0] b);
        rst4 = 1'b0;
        en4  = 1'b0;
        a4   = a;
        b4   = b;
        step();
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_result", res4, 32'd0);
        rst4 = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        reset4(v.a, v.b);
        en4 = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk({v.nm, "_busy_done"}, {31'd0, done4}, 32'd0);
            chk({v.nm, "_busy_result"}, res4, 32'd0);
        end
        step();
        chk({v.nm, "_done"}, {31'd0, done4}, 32'd1);
        chk({v.nm, "_result"}, res4, v.exp);
        // Output must hold while operands and enable wander.
        for (int h = 0; h < 10; h++) begin
            a4  = {$urandom, $urandom, $urandom, $urandom};
            b4  = {$urandom, $urandom, $urandom, $urandom};
            en4 = h[0];
            step();
            chk({v.nm, "_hold_done"}, {31'd0, done4}, 32'd1);
            chk({v.nm, "_hold_result"}, res4, v.exp);
        end
    endtask

    initial begin
        rst4 = 1'b0; en4 = 1'b0; a4 = '0; b4 = '0;
        rst1 = 1'b0; en1 = 1'b0; a1 = '0; b1 = '0;

        // Elements are listed high index first: {e3, e2, e1, e0}.
        tbl[0] = '{"basic",  {32'd4, 32'd3, 32'd2, 32'd1},
                             {32'd8, 32'd7, 32'd6, 32'd5}, 32'd70};
        tbl[1] = '{"ovf",    {32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF},
                             {32'd0, 32'd0, 32'd2, 32'd2}, 32'hFFFF_FFFE};
        tbl[2] = '{"ones",   {4{32'd1}}, {4{32'd1}}, 32'd4};
        tbl[3] = '{"neg",    {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 32'd4};
        tbl[4] = '{"trunc",  {32'd0, 32'd3, 32'd0, 32'h0001_0000},
                             {32'd0, 32'd3, 32'd0, 32'h0001_0000}, 32'd9};
        tbl[5] = '{"wrap",   {32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF},
                             {32'd1, 32'd1, 32'd1, 32'd1}, 32'd2};

        #2;
        chk("por_done4", {31'd0, done4}, 32'd0);
        chk("por_result4", res4, 32'd0);
        chk("por_done1", {31'd0, done1}, 32'd0);
        chk("por_result1", res1, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Enable gating: 2 enabled, 3 frozen, then done on 7th edge overall.
        reset4(tbl[0].a, tbl[0].b);
        en4 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 2) en4 = 1'b0;
            if (e == 5) en4 = 1'b1;
            chk("gate_done", {31'd0, done4}, (e == 7) ? 32'd1 : 32'd0);
            chk("gate_result", res4, (e == 7) ? 32'd70 : 32'd0);
        end

        // Reset mid-run discards the partial sum.
        reset4(tbl[0].a, tbl[0].b);
        en4 = 1'b1;
        step();
        step();
        #2 rst4 = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done4}, 32'd0);
        chk("midrst_result", res4, 32'd0);
        a4 = {4{32'd1}};
        b4 = {4{32'd1}};
        @(negedge clk);
        rst4 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("midrst_ones_done", {31'd0, done4}, (e == 4) ? 32'd1 : 32'd0);
            chk("midrst_ones_result", res4, (e == 4) ? 32'd4 : 32'd0);
        end

        // Back-to-back: asynchronous reset from DONE clears outputs at once.
        #2 rst4 = 1'b0;
        #1;
        chk("b2b_drop_done", {31'd0, done4}, 32'd0);
        chk("b2b_drop_result", res4, 32'd0);
        a4 = {32'd0, 32'd0, 32'd0, 32'd2};
        b4 = {32'd0, 32'd0, 32'd0, 32'd3};
        @(negedge clk);
        rst4 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("b2b_done", {31'd0, done4}, (e == 4) ? 32'd1 : 32'd0);
            chk("b2b_result", res4, (e == 4) ? 32'd6 : 32'd0);
        end

        // Reset coinciding with the final accumulating edge: reset wins.
        reset4(tbl[0].a, tbl[0].b);
        en4 = 1'b1;
        step();
        step();
        step();
        @(posedge clk);
        rst4 = 1'b0;
        #1;
        chk("race_done", {31'd0, done4}, 32'd0);
        chk("race_result", res4, 32'd0);
        rst4 = 1'b1;

        // Single-element configuration.
        a1 = 32'd7;
        b1 = 32'd9;
        step();
        rst1 = 1'b1;
        step();
        chk("len1_frozen_done", {31'd0, done1}, 32'd0);
        chk("len1_frozen_result", res1, 32'd0);
        en1 = 1'b1;
        step();
        chk("len1_done", {31'd0, done1}, 32'd1);
        chk("len1_result", res1, 32'd63);
        a1 = 32'd5;
        step();
        chk("len1_hold", res1, 32'd63);

        rst1 = 1'b0;
        a1   = '0;
        b1   = '0;
        step();
        rst1 = 1'b1;
        step();
        chk("len1_zero_done", {31'd0, done1}, 32'd1);
        chk("len1_zero_result", res1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
